cache_miss_sequencer: RTL and testbench
=======================================

// Module: cache_miss_sequencer
// PURPOSE
//  Central cache controller FSM between the CPU port, tag/data arrays and main memory.
//  Accepts one CPU read/write at a time, performs a tag lookup and serves hits.
//  On a miss it writes back the dirty victim line, fetches the missing block, fills it,
//  then completes the access. Single outstanding request; no pipelining of CPU accesses.
// PARAMETERS
//  ADDRESS_WIDTH  32  CPU/memory byte-address width
//  BLOCK_SIZE     32  line size in bytes (power of 2); offset bits = $clog2(BLOCK_SIZE)
//  NUM_WAYS       4   associativity; way index width WW = $clog2(NUM_WAYS)
//  COUNTER_WIDTH  8   width of the saturating performance counters
// PORTS
//  clk                in   1       clock, rising edge
//  rst_n              in   1       asynchronous reset, active low
//  request            in   1       CPU request strobe, sampled in IDLE only
//  read / write       in   1/1     access type; exactly one must be high with request
//  cpuRequestAddress  in   AW      CPU byte address
//  lookupEnable       out  1       tag-array lookup strobe (LOOKUP state)
//  lookupAddress      out  AW      registered CPU address driven to the tag array
//  hit / hitWay       in   1/WW    tag-array result, valid in the cycle of lookupEnable
//  victimWay          in   WW      replacement choice, valid with hit=0
//  victimDirty        in   1       victim line is valid and dirty
//  victimAddress      in   AW      base address of the victim line
//  writeBackReq       out  1       level request to memory; writeBackAddress stable
//  writeBackAddress   out  AW      registered victimAddress
//  writeBackAck       in   1       memory has stored writeBackData
//  fetchReq           out  1       level request to memory; fetchAddress stable
//  fetchAddress       out  AW      lookupAddress with offset bits cleared
//  fetchValid         in   1       fetchedData valid this cycle
//  fillEnable / fillWay out 1/WW   one-cycle line write of fetchedData into victimWay
//  accessEnable       out  1       data-array read/write strobe (RESPOND state)
//  accessWrite        out  1       1 = write dataFromRegister, 0 = read to dataToRegister
//  accessWay          out  WW      way of the access (hitWay or filled victimWay)
//  readyToSend        out  1       one-cycle completion pulse to CPU
//  busy               out  1       high in every state except IDLE
//  hitCount/missCount/writeBackCount out CW  performance counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, registered address/way/type = 0. Reset mid-operation
//   drops any in-flight memory request immediately (req lines low on the same edge).
//  IDLE: request && (read ^ write) -> capture address/type, go LOOKUP. request with
//   read==write is ignored (no state change, no pulse).
//  LOOKUP (1 cycle, lookupEnable=1): hit -> RESPOND, accessWay=hitWay;
//   miss & victimDirty -> WRITEBACK; miss & !victimDirty -> FETCH; victim way/address latched.
//  WRITEBACK: writeBackReq=1 until writeBackAck sampled high -> FETCH (req low next cycle).
//  FETCH: fetchReq=1 until fetchValid sampled high -> FILL.
//  FILL (1 cycle): fillEnable=1, fillWay=latched victimWay -> RESPOND, accessWay=victimWay.
//  RESPOND (1 cycle): accessEnable=1, accessWrite=latched type, readyToSend=1 -> IDLE.
//  Latency: hit = 2 cycles after request edge (readyToSend in cycle T+2); clean miss =
//   T+2 + fetch wait + 2; dirty miss adds writeback wait.
//  writeBackAck/fetchValid outside their own state are ignored. Ack and request in the
//   same cycle is legal (zero wait beyond the 1 request cycle).
//  request while busy is ignored; CPU must hold nothing after capture.
//  No timeout: FSM waits indefinitely for memory.
// CONFIGURATION
//  CACHE_PERF_COUNTERS_EN defined: hitCount += 1 per LOOKUP hit, missCount += 1 per
//   LOOKUP miss, writeBackCount += 1 per writeBackAck accepted; all saturate at
//   2**COUNTER_WIDTH-1, reset to 0. Not defined: counter ports tied to 0, no flops.
// TESTING
//  Read hit: req read addr 0x100, hit=1 hitWay=2 -> readyToSend at T+2, accessWay=2, no mem req.
//  Clean miss: write 0x1234, hit=0 victimDirty=0 victimWay=1 -> fetchReq with fetchAddress
//   0x1220; fetchValid after 5 cycles -> fillEnable fillWay=1, then accessWrite=1 pulse.
//  Dirty miss: victimAddress 0x8000 -> writeBackReq addr 0x8000 until ack, then fetchReq;
//   ack and fetchValid asserted early (in IDLE) are ignored.
//  Illegal/busy: request with read=write=1 -> stays IDLE; request during FETCH -> ignored.
//  Reset in WRITEBACK: rst_n low -> writeBackReq, busy drop immediately, state IDLE.
//  Perf (macro on, CW=2): 5 hits -> hitCount saturates at 3; macro off -> counters read 0.

Source files
------------

// File: rtl/cache_miss_sequencer.sv
// Cache controller FSM: tag lookup, dirty-victim writeback, line fetch/fill, then CPU access.
// Optional performance counters are compiled in with `define CACHE_PERF_COUNTERS_EN.
module cache_miss_sequencer #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE    = 32,
  parameter int unsigned NUM_WAYS      = 4,
  parameter int unsigned COUNTER_WIDTH = 8,
  localparam int unsigned AW = ADDRESS_WIDTH,
  localparam int unsigned WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int unsigned CW = COUNTER_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          request,
  input  logic          read,
  input  logic          write,
  input  logic [AW-1:0] cpuRequestAddress,
  output logic          lookupEnable,
  output logic [AW-1:0] lookupAddress,
  input  logic          hit,
  input  logic [WW-1:0] hitWay,
  input  logic [WW-1:0] victimWay,
  input  logic          victimDirty,
  input  logic [AW-1:0] victimAddress,
  output logic          writeBackReq,
  output logic [AW-1:0] writeBackAddress,
  input  logic          writeBackAck,
  output logic          fetchReq,
  output logic [AW-1:0] fetchAddress,
  input  logic          fetchValid,
  output logic          fillEnable,
  output logic [WW-1:0] fillWay,
  output logic          accessEnable,
  output logic          accessWrite,
  output logic [WW-1:0] accessWay,
  output logic          readyToSend,
  output logic          busy,
  output logic [CW-1:0] hitCount,
  output logic [CW-1:0] missCount,
  output logic [CW-1:0] writeBackCount
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_FETCH     = 3'd3;
  localparam logic [2:0] S_FILL      = 3'd4;
  localparam logic [2:0] S_RESPOND   = 3'd5;

  localparam logic [AW-1:0] OFFSET_MASK = AW'(BLOCK_SIZE - 1);

  logic [2:0]    state_q, state_d;
  logic          write_q, write_d;
  logic [WW-1:0] victim_way_q, victim_way_d;
  logic          lookup_enable_q, lookup_enable_d;
  logic [AW-1:0] lookup_address_q, lookup_address_d;
  logic          write_back_req_q, write_back_req_d;
  logic [AW-1:0] write_back_address_q, write_back_address_d;
  logic          fetch_req_q, fetch_req_d;
  logic [AW-1:0] fetch_address_q, fetch_address_d;
  logic          fill_enable_q, fill_enable_d;
  logic [WW-1:0] fill_way_q, fill_way_d;
  logic          access_enable_q, access_enable_d;
  logic          access_write_q, access_write_d;
  logic [WW-1:0] access_way_q, access_way_d;
  logic          ready_to_send_q, ready_to_send_d;
  logic          busy_q, busy_d;

  // Next state plus registered outputs decoded from the state being entered.
  always_comb begin
    state_d              = state_q;
    write_d              = write_q;
    victim_way_d         = victim_way_q;
    lookup_address_d     = lookup_address_q;
    write_back_address_d = write_back_address_q;
    fetch_address_d      = fetch_address_q;
    access_way_d         = access_way_q;
    fill_way_d           = fill_way_q;

    case (state_q)
      S_IDLE: begin
        if (request && (read ^ write)) begin
          state_d          = S_LOOKUP;
          write_d          = write;
          lookup_address_d = cpuRequestAddress;
          fetch_address_d  = cpuRequestAddress & ~OFFSET_MASK;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          state_d      = S_RESPOND;
          access_way_d = hitWay;
        end else begin
          victim_way_d         = victimWay;
          write_back_address_d = victimAddress;
          state_d              = victimDirty ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: if (writeBackAck) state_d = S_FETCH;
      S_FETCH:     if (fetchValid) state_d = S_FILL;
      S_FILL: begin
        state_d      = S_RESPOND;
        access_way_d = victim_way_q;
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (state_d == S_FILL) fill_way_d = victim_way_q;

    lookup_enable_d  = (state_d == S_LOOKUP);
    write_back_req_d = (state_d == S_WRITEBACK);
    fetch_req_d      = (state_d == S_FETCH);
    fill_enable_d    = (state_d == S_FILL);
    access_enable_d  = (state_d == S_RESPOND);
    access_write_d   = (state_d == S_RESPOND) && write_q;
    ready_to_send_d  = (state_d == S_RESPOND);
    busy_d           = (state_d != S_IDLE);
  end

  // Async reset clears every request line on the same edge it arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= S_IDLE;
      write_q              <= 1'b0;
      victim_way_q         <= '0;
      lookup_enable_q      <= 1'b0;
      lookup_address_q     <= '0;
      write_back_req_q     <= 1'b0;
      write_back_address_q <= '0;
      fetch_req_q          <= 1'b0;
      fetch_address_q      <= '0;
      fill_enable_q        <= 1'b0;
      fill_way_q           <= '0;
      access_enable_q      <= 1'b0;
      access_write_q       <= 1'b0;
      access_way_q         <= '0;
      ready_to_send_q      <= 1'b0;
      busy_q               <= 1'b0;
    end else begin
      state_q              <= state_d;
      write_q              <= write_d;
      victim_way_q         <= victim_way_d;
      lookup_enable_q      <= lookup_enable_d;
      lookup_address_q     <= lookup_address_d;
      write_back_req_q     <= write_back_req_d;
      write_back_address_q <= write_back_address_d;
      fetch_req_q          <= fetch_req_d;
      fetch_address_q      <= fetch_address_d;
      fill_enable_q        <= fill_enable_d;
      fill_way_q           <= fill_way_d;
      access_enable_q      <= access_enable_d;
      access_write_q       <= access_write_d;
      access_way_q         <= access_way_d;
      ready_to_send_q      <= ready_to_send_d;
      busy_q               <= busy_d;
    end
  end

  assign lookupEnable     = lookup_enable_q;
  assign lookupAddress    = lookup_address_q;
  assign writeBackReq     = write_back_req_q;
  assign writeBackAddress = write_back_address_q;
  assign fetchReq         = fetch_req_q;
  assign fetchAddress     = fetch_address_q;
  assign fillEnable       = fill_enable_q;
  assign fillWay          = fill_way_q;
  assign accessEnable     = access_enable_q;
  assign accessWrite      = access_write_q;
  assign accessWay        = access_way_q;
  assign readyToSend      = ready_to_send_q;
  assign busy             = busy_q;

`ifdef CACHE_PERF_COUNTERS_EN
  logic [CW-1:0] hit_count_q, hit_count_d;
  logic [CW-1:0] miss_count_q, miss_count_d;
  logic [CW-1:0] write_back_count_q, write_back_count_d;

  // Saturating event counters; they stick at all-ones rather than wrap.
  always_comb begin
    hit_count_d        = hit_count_q;
    miss_count_d       = miss_count_q;
    write_back_count_d = write_back_count_q;
    if (state_q == S_LOOKUP) begin
      if (hit) begin
        if (hit_count_q != '1) hit_count_d = hit_count_q + CW'(1);
      end else begin
        if (miss_count_q != '1) miss_count_d = miss_count_q + CW'(1);
      end
    end
    if ((state_q == S_WRITEBACK) && writeBackAck && (write_back_count_q != '1))
      write_back_count_d = write_back_count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q        <= '0;
      miss_count_q       <= '0;
      write_back_count_q <= '0;
    end else begin
      hit_count_q        <= hit_count_d;
      miss_count_q       <= miss_count_d;
      write_back_count_q <= write_back_count_d;
    end
  end

  assign hitCount       = hit_count_q;
  assign missCount      = miss_count_q;
  assign writeBackCount = write_back_count_q;
`else
  assign hitCount       = '0;
  assign missCount      = '0;
  assign writeBackCount = '0;
`endif

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Directed, table-driven bench for cache_miss_sequencer (counters built with COUNTER_WIDTH=2).
module tb_cache_miss_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        request, read, write;
  logic [31:0] cpuRequestAddress;
  logic        lookupEnable;
  logic [31:0] lookupAddress;
  logic        hit;
  logic [1:0]  hitWay, victimWay;
  logic        victimDirty;
  logic [31:0] victimAddress;
  logic        writeBackReq;
  logic [31:0] writeBackAddress;
  logic        writeBackAck;
  logic        fetchReq;
  logic [31:0] fetchAddress;
  logic        fetchValid;
  logic        fillEnable;
  logic [1:0]  fillWay;
  logic        accessEnable, accessWrite;
  logic [1:0]  accessWay;
  logic        readyToSend, busy;
  logic [1:0]  hitCount, missCount, writeBackCount;

  int n_checks = 0;
  int n_errors = 0;

  cache_miss_sequencer #(
    .ADDRESS_WIDTH(32), .BLOCK_SIZE(32), .NUM_WAYS(4), .COUNTER_WIDTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .request(request), .read(read), .write(write),
    .cpuRequestAddress(cpuRequestAddress),
    .lookupEnable(lookupEnable), .lookupAddress(lookupAddress),
    .hit(hit), .hitWay(hitWay), .victimWay(victimWay),
    .victimDirty(victimDirty), .victimAddress(victimAddress),
    .writeBackReq(writeBackReq), .writeBackAddress(writeBackAddress),
    .writeBackAck(writeBackAck),
    .fetchReq(fetchReq), .fetchAddress(fetchAddress), .fetchValid(fetchValid),
    .fillEnable(fillEnable), .fillWay(fillWay),
    .accessEnable(accessEnable), .accessWrite(accessWrite), .accessWay(accessWay),
    .readyToSend(readyToSend), .busy(busy),
    .hitCount(hitCount), .missCount(missCount), .writeBackCount(writeBackCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req, rd, wr;
    logic [31:0] addr;
    logic        hit;
    logic [1:0]  hway, vway;
    logic        vdirty;
    logic [31:0] vaddr;
    logic        ack, fv;
    logic [7:0]  flags;  // {busy,lookup,wbReq,fetchReq,fill,access,accessWrite,ready}
    logic [1:0]  aw, fw;
    logic [31:0] la, fa, wba;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] flags_now();
    return {busy, lookupEnable, writeBackReq, fetchReq, fillEnable,
            accessEnable, accessWrite, readyToSend};
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef CACHE_PERF_COUNTERS_EN
    return (n > 3) ? 32'd3 : 32'(n);
`else
    return (n < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rq, input logic r, input logic w, input logic [31:0] a,
                       input logic h, input logic [1:0] hw, input logic [1:0] vw,
                       input logic vd, input logic [31:0] va, input logic ak, input logic f);
    request = rq; read = r; write = w; cpuRequestAddress = a;
    hit = h; hitWay = hw; victimWay = vw; victimDirty = vd; victimAddress = va;
    writeBackAck = ak; fetchValid = f;
  endtask

  task automatic row(input logic rq, input logic r, input logic w, input logic [31:0] a,
                     input logic h, input logic [1:0] hw, input logic [1:0] vw,
                     input logic vd, input logic [31:0] va, input logic ak, input logic f,
                     input logic [7:0] fl, input logic [1:0] aw, input logic [1:0] fw,
                     input logic [31:0] la, input logic [31:0] fa, input logic [31:0] wba);
    vec_t v;
    v.req = rq; v.rd = r; v.wr = w; v.addr = a; v.hit = h; v.hway = hw; v.vway = vw;
    v.vdirty = vd; v.vaddr = va; v.ack = ak; v.fv = f;
    v.flags = fl; v.aw = aw; v.fw = fw; v.la = la; v.fa = fa; v.wba = wba;
    tbl.push_back(v);
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();

    // Read hit 0x100 way 2
    row(1,1,0,32'h100,  0,2'd0,2'd0,0,32'h0,   0,0, 8'hC0,2'd0,2'd0,32'h100, 32'h100, 32'h0);
    row(0,0,0,32'h0,    1,2'd2,2'd0,0,32'h0,   0,0, 8'h85,2'd2,2'd0,32'h100, 32'h100, 32'h0);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,0, 8'h00,2'd2,2'd0,32'h100, 32'h100, 32'h0);
    // Clean write miss 0x1234, victim way 1, request during FETCH ignored
    row(1,0,1,32'h1234, 0,2'd0,2'd0,0,32'h0,   0,0, 8'hC0,2'd2,2'd0,32'h1234,32'h1220,32'h0);
    row(0,0,0,32'h0,    0,2'd0,2'd1,0,32'h4000,0,0, 8'h90,2'd2,2'd0,32'h1234,32'h1220,32'h4000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,0, 8'h90,2'd2,2'd0,32'h1234,32'h1220,32'h4000);
    row(1,1,0,32'h9999, 0,2'd0,2'd0,0,32'h0,   0,0, 8'h90,2'd2,2'd0,32'h1234,32'h1220,32'h4000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,0, 8'h90,2'd2,2'd0,32'h1234,32'h1220,32'h4000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,0, 8'h90,2'd2,2'd0,32'h1234,32'h1220,32'h4000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,1, 8'h88,2'd2,2'd1,32'h1234,32'h1220,32'h4000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,0, 8'h87,2'd1,2'd1,32'h1234,32'h1220,32'h4000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,0, 8'h00,2'd1,2'd1,32'h1234,32'h1220,32'h4000);
    // Illegal type combinations and stray memory handshakes in IDLE
    row(1,1,1,32'h5000, 0,2'd0,2'd0,0,32'h0,   0,0, 8'h00,2'd1,2'd1,32'h1234,32'h1220,32'h4000);
    row(1,0,0,32'h5000, 0,2'd0,2'd0,0,32'h0,   0,0, 8'h00,2'd1,2'd1,32'h1234,32'h1220,32'h4000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   1,1, 8'h00,2'd1,2'd1,32'h1234,32'h1220,32'h4000);
    // Dirty read miss 0x2040, victim 0x8000 way 3
    row(1,1,0,32'h2040, 0,2'd0,2'd0,0,32'h0,   1,1, 8'hC0,2'd1,2'd1,32'h2040,32'h2040,32'h4000);
    row(0,0,0,32'h0,    0,2'd0,2'd3,1,32'h8000,0,0, 8'hA0,2'd1,2'd1,32'h2040,32'h2040,32'h8000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,1, 8'hA0,2'd1,2'd1,32'h2040,32'h2040,32'h8000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   1,0, 8'h90,2'd1,2'd1,32'h2040,32'h2040,32'h8000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,1, 8'h88,2'd1,2'd3,32'h2040,32'h2040,32'h8000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,0, 8'h85,2'd3,2'd3,32'h2040,32'h2040,32'h8000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,0, 8'h00,2'd3,2'd3,32'h2040,32'h2040,32'h8000);
    // Write hit way 0
    row(1,0,1,32'h3000, 0,2'd0,2'd0,0,32'h0,   0,0, 8'hC0,2'd3,2'd3,32'h3000,32'h3000,32'h8000);
    row(0,0,0,32'h0,    1,2'd0,2'd0,0,32'h0,   0,0, 8'h87,2'd0,2'd3,32'h3000,32'h3000,32'h8000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,0, 8'h00,2'd0,2'd3,32'h3000,32'h3000,32'h8000);
    // Dirty miss with zero-wait ack and fetch
    row(1,1,0,32'h40,   0,2'd0,2'd0,0,32'h0,   0,0, 8'hC0,2'd0,2'd3,32'h40,  32'h40,  32'h8000);
    row(0,0,0,32'h0,    0,2'd0,2'd2,1,32'h7000,1,0, 8'hA0,2'd0,2'd3,32'h40,  32'h40,  32'h7000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   1,1, 8'h90,2'd0,2'd3,32'h40,  32'h40,  32'h7000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,1, 8'h88,2'd0,2'd2,32'h40,  32'h40,  32'h7000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,0, 8'h85,2'd2,2'd2,32'h40,  32'h40,  32'h7000);
    row(0,0,0,32'h0,    0,2'd0,2'd0,0,32'h0,   0,0, 8'h00,2'd2,2'd2,32'h40,  32'h40,  32'h7000);

    // Reset state
    #12;
    chk("reset flags", 32'(flags_now()), 32'h0);
    chk("reset lookupAddress", lookupAddress, 32'h0);
    chk("reset fetchAddress", fetchAddress, 32'h0);
    chk("reset writeBackAddress", writeBackAddress, 32'h0);
    chk("reset ways", 32'({accessWay, fillWay}), 32'h0);
    chk("reset counters", 32'({hitCount, missCount, writeBackCount}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].hit, tbl[i].hway,
            tbl[i].vway, tbl[i].vdirty, tbl[i].vaddr, tbl[i].ack, tbl[i].fv);
      tick();
      chk($sformatf("row%0d flags", i), 32'(flags_now()), 32'(tbl[i].flags));
      chk($sformatf("row%0d accessWay", i), 32'(accessWay), 32'(tbl[i].aw));
      chk($sformatf("row%0d fillWay", i), 32'(fillWay), 32'(tbl[i].fw));
      chk($sformatf("row%0d lookupAddress", i), lookupAddress, tbl[i].la);
      chk($sformatf("row%0d fetchAddress", i), fetchAddress, tbl[i].fa);
      chk($sformatf("row%0d writeBackAddress", i), writeBackAddress, tbl[i].wba);
    end
    idle_in();

    // 2 hits, 3 misses, 2 writebacks so far
    chk("hitCount after table", 32'(hitCount), exp_cnt(2));
    chk("missCount after table", 32'(missCount), exp_cnt(3));
    chk("writeBackCount after table", 32'(writeBackCount), exp_cnt(2));

    // Five more hits: hit counter saturates
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2'd1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      chk($sformatf("perf hit%0d respond flags", k), 32'(flags_now()), 32'h85);
      idle_in();
      tick();
    end
    chk("hitCount saturated", 32'(hitCount), exp_cnt(7));
    chk("missCount held", 32'(missCount), exp_cnt(3));
    chk("writeBackCount held", 32'(writeBackCount), exp_cnt(2));

    // Asynchronous reset while waiting in WRITEBACK
    drive(1'b1, 1'b1, 1'b0, 32'h600, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd1, 1'b1, 32'h9000, 1'b0, 1'b0);
    tick();
    chk("pre-reset writeback flags", 32'(flags_now()), 32'hA0);
    chk("pre-reset writeBackAddress", writeBackAddress, 32'h9000);
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    chk("async reset flags", 32'(flags_now()), 32'h0);
    chk("async reset writeBackAddress", writeBackAddress, 32'h0);
    tick();
    chk("held reset flags", 32'(flags_now()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h700, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("post-reset lookup flags", 32'(flags_now()), 32'hC0);
    chk("post-reset lookupAddress", lookupAddress, 32'h700);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2'd3, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("post-reset respond flags", 32'(flags_now()), 32'h85);
    chk("post-reset accessWay", 32'(accessWay), 32'd3);
    chk("post-reset hitCount", 32'(hitCount), exp_cnt(1));
    chk("post-reset missCount", 32'(missCount), exp_cnt(0));
    chk("post-reset writeBackCount", 32'(writeBackCount), exp_cnt(0));
    idle_in();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
